pgm_sched: RTL

Replay scheduler for the packet generator. After a template packet has been stored in PGM_RAM and the start flag fires, it issues RAM read addresses to stream the stored packet to the downstream module. The packet is repeated with a configurable inter-packet gap and burst count, and replay obeys downstream almost-full at packet boundaries. It sits between PGM_RAM's read port and the pgm output datapath, and is configured by the pgm register block.

---
 rtl/pgm_sched.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/pgm_sched.sv
// rtl/pgm_sched.sv - replay scheduler streaming a stored template packet out of PGM_RAM
module pgm_sched #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 134
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] last_addr,
    input  logic              stop,
    input  logic              cfg_wr,
    input  logic              cfg_addr,
    input  logic [31:0]       cfg_wdata,
    output logic              ram_rd_en,
    output logic [ADDR_W-1:0] ram_rd_addr,
    input  logic [143:0]      ram_rdata,
    output logic [DATA_W-1:0] out_data,
    output logic              out_data_wr,
    output logic              out_valid,
    output logic              out_valid_wr,
    input  logic              in_alf,
    output logic              busy,
    output logic              done,
    output logic [31:0]       pkt_cnt
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ARM  = 2'd1;
    localparam logic [1:0] S_READ = 2'd2;
    localparam logic [1:0] S_GAP  = 2'd3;

    logic [1:0]        state;
    logic [31:0]       gap_reg;
    logic [31:0]       burst_reg;
    logic [31:0]       gap_sh;
    logic [31:0]       burst_sh;
    logic [ADDR_W-1:0] last_sh;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       gap_cnt;
    logic              rd_en_q;
    logic              tail_q;
    logic [31:0]       cnt_eff;
    logic              arm_exit;
    logic              is_tail;
    logic              start_ok;
    logic              unused_rdata;

    // RAM bits above the flit carry nothing for this block
    assign unused_rdata = ^ram_rdata[143:DATA_W];

    assign start_ok = (state == S_IDLE) && start && (last_addr != '0);

    // With gap 0 the previous tail is still in the output register when ARM
    // decides, so the burst check counts that tail before pkt_cnt shows it.
    always_comb begin
        cnt_eff = pkt_cnt;
        if (tail_q && (pkt_cnt != 32'hFFFF_FFFF))
            cnt_eff = pkt_cnt + 32'd1;
    end

    assign arm_exit    = stop || ((burst_sh != '0) && (cnt_eff == burst_sh));
    assign is_tail     = (state == S_READ) && (addr_q == last_sh);
    assign ram_rd_en   = (state == S_READ) || ((state == S_ARM) && !arm_exit && !in_alf);
    assign ram_rd_addr = (state == S_READ) ? addr_q : '0;
    assign busy        = (state != S_IDLE);

    // Read data arrives one cycle after the read, so the output strobes are the delayed read strobes
    assign out_data_wr  = rd_en_q;
    assign out_valid_wr = tail_q;
    assign out_valid    = tail_q;
    assign out_data     = rd_en_q ? ram_rdata[DATA_W-1:0] : '0;

    // Configuration registers, writable in any state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gap_reg   <= '0;
            burst_reg <= 32'd1;
        end else if (cfg_wr) begin
            if (cfg_addr) burst_reg <= cfg_wdata;
            else          gap_reg   <= cfg_wdata;
        end
    end

    // Replay FSM with run-time shadows of the configuration
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            gap_sh   <= '0;
            burst_sh <= '0;
            last_sh  <= '0;
            addr_q   <= '0;
            gap_cnt  <= '0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start_ok) begin
                        state    <= S_ARM;
                        gap_sh   <= gap_reg;
                        burst_sh <= burst_reg;
                        last_sh  <= last_addr;
                    end
                end
                S_ARM: begin
                    if (arm_exit) begin
                        state <= S_IDLE;
                        done  <= 1'b1;
                    end else if (!in_alf) begin
                        state  <= S_READ;
                        addr_q <= {{(ADDR_W-1){1'b0}}, 1'b1};
                    end
                end
                S_READ: begin
                    if (addr_q == last_sh) begin
                        gap_cnt <= '0;
                        state   <= (gap_sh == '0) ? S_ARM : S_GAP;
                    end else begin
                        addr_q <= addr_q + 1'b1;
                    end
                end
                default: begin
                    gap_cnt <= gap_cnt + 32'd1;
                    if (gap_cnt == gap_sh - 32'd1)
                        state <= S_ARM;
                end
            endcase
        end
    end

    // Output stage registers aligned with the RAM read latency
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_en_q <= 1'b0;
            tail_q  <= 1'b0;
        end else begin
            rd_en_q <= ram_rd_en;
            tail_q  <= is_tail;
        end
    end

    // Packet counter: cleared on an accepted start, saturating on each tail flit
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            pkt_cnt <= '0;
        else if (start_ok)
            pkt_cnt <= '0;
        else if (tail_q && (pkt_cnt != 32'hFFFF_FFFF))
            pkt_cnt <= pkt_cnt + 32'd1;
    end

endmodule
